// File: rtl/fifo_pkg.sv
// Shared constants for the narrow/wide width-converting FIFOs (upsize and downsize).
package fifo_pkg;

  // Number of narrow words packed into one wide word.
  localparam int WIDTH_RATIO      = 2;
  localparam int DEF_W_DATA_WIDTH = 4;
  localparam int DEF_W_ADDR_WIDTH = 3;

  // Which of the two requests is accepted this cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/pack_reg_file.sv
// Register file: narrow synchronous write port, wide combinational read port that
// returns the narrow word at raddr (low half) and the one after it (high half).
module pack_reg_file
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_W_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_W_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [ADDR_WIDTH-1:0]             waddr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [ADDR_WIDTH-1:0]             raddr,
  output logic [WIDTH_RATIO*DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; its contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // raddr is always even, so OR-ing in 1 selects the second word of the pair.
  assign rdata = {mem[raddr | ADDR_WIDTH'(1)], mem[raddr]};

endmodule

// File: rtl/fifo_upsize.sv
// Narrow-in / wide-out FIFO: two consecutive narrow writes form one wide word,
// read first-word fall-through, earlier word in the low half.
module fifo_upsize
  import fifo_pkg::*;
#(
  parameter int W_DATA_WIDTH = DEF_W_DATA_WIDTH,
  parameter int W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
  parameter int R_DATA_WIDTH = WIDTH_RATIO * W_DATA_WIDTH,
  parameter int R_ADDR_WIDTH = W_ADDR_WIDTH - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr,
  input  logic [W_DATA_WIDTH-1:0] w_data,
  input  logic                    rd,
  output logic [R_DATA_WIDTH-1:0] r_data,
  output logic                    empty,
  output logic                    full,
  output logic [W_ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 1 << W_ADDR_WIDTH;
  localparam int LVL_W = W_ADDR_WIDTH + 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PAIR = LVL_W'(WIDTH_RATIO);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  generate
    if (R_DATA_WIDTH != WIDTH_RATIO * W_DATA_WIDTH || R_ADDR_WIDTH != W_ADDR_WIDTH - 1
        || W_ADDR_WIDTH < 1) begin : g_bad_params
      $error("fifo_upsize: unsupported parameter combination");
    end
  endgenerate

  // The read pointer is kept as a narrow-word address that steps by two, so it
  // wraps modulo the wide depth and needs no separate width when R_ADDR_WIDTH is 0.
  logic [W_ADDR_WIDTH-1:0] wr_ptr;
  logic [W_ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]        level_q;
  logic [R_DATA_WIDTH-1:0] head_word;
  logic                    wr_en;
  logic                    rd_en;
  fifo_op_e                op;

  assign empty = (level_q < LVL_PAIR);
  assign full  = (level_q == LVL_FULL);
  assign level = level_q;

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op = OP_IDLE;
    case ({wr_en, rd_en})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + W_ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + W_ADDR_WIDTH'(WIDTH_RATIO);
      end
      case (op)
        OP_WR:   level_q <= level_q + LVL_ONE;
        OP_RD:   level_q <= level_q - LVL_PAIR;
        OP_BOTH: level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  pack_reg_file #(
    .DATA_WIDTH (W_DATA_WIDTH),
    .ADDR_WIDTH (W_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (w_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  // Stale storage behind an empty head is masked so r_data reads as zero.
  assign r_data = empty ? '0 : head_word;

endmodule

// File: tb/tb_fifo_upsize.sv
// Self-checking bench for fifo_upsize: directed steps plus a randomized run,
// all compared against a queue-of-narrow-words reference model.
module tb_fifo_upsize;

  localparam int WD    = 4;
  localparam int WA    = 3;
  localparam int RD_W  = 2 * WD;
  localparam int DEPTH = 1 << WA;

  logic            clk;
  logic            reset_n;
  logic            wr;
  logic [WD-1:0]   w_data;
  logic            rd;
  logic [RD_W-1:0] r_data;
  logic            empty;
  logic            full;
  logic [WA:0]     level;

  int n_checks;
  int n_fail;
  int n_wr_acc;

  logic [WD-1:0] q [$];

  fifo_upsize #(
    .W_DATA_WIDTH (WD),
    .W_ADDR_WIDTH (WA)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .w_data  (w_data),
    .rd      (rd),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model's stored narrow words.
  task automatic check_all(input string tag);
    int          n;
    logic [31:0] exp_data;
    n = q.size();
    exp_data = 0;
    if (n >= 2) exp_data = 32'(q[0]) | (32'(q[1]) << WD);
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n < 2));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".r_data"}, 32'(r_data), exp_data);
  endtask

  // One clock cycle: drive, let the edge pass, update the model, sample at negedge.
  task automatic step(input logic w, input logic r, input logic [WD-1:0] d, input string tag);
    bit do_wr;
    bit do_rd;
    wr = w; rd = r; w_data = d;
    do_wr = w && (q.size() < DEPTH);
    do_rd = r && (q.size() >= 2);
    @(posedge clk);
    if (do_rd) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end
    if (do_wr) begin
      q.push_back(d);
      n_wr_acc++;
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cycles;
    int target;
    n_checks = 0; n_fail = 0; n_wr_acc = 0;
    wr = 1'b0; rd = 1'b0; w_data = '0; reset_n = 1'b0;

    do_reset();
    check_all("reset");

    // Pairing and little-endian packing.
    step(1'b1, 1'b0, 4'hA, "wr_a");
    check("wr_a.r_data_lit", 32'(r_data), 32'h00);
    step(1'b1, 1'b0, 4'h5, "wr_5");
    check("wr_5.r_data_lit", 32'(r_data), 32'h5A);
    step(1'b0, 1'b1, 4'h0, "drain0");

    // Fill to full, overflow write dropped, drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, WD'(i), "fill");
    check("full_lit", 32'(full), 32'd1);
    step(1'b1, 1'b0, 4'hF, "overflow");
    check("rd0_lit", 32'(r_data), 32'h21);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0, "drain_full");
    check("drained_empty_lit", 32'(empty), 32'd1);

    // Level 3 with simultaneous read and write.
    step(1'b1, 1'b0, 4'h3, "l3a");
    step(1'b1, 1'b0, 4'hC, "l3b");
    step(1'b1, 1'b0, 4'h7, "l3c");
    step(1'b1, 1'b1, 4'h9, "l3_rdwr");
    check("l3_rdwr.r_data_lit", 32'(r_data), 32'h97);

    // Level 1: read ignored, also when the same-cycle write completes a pair.
    step(1'b0, 1'b1, 4'h0, "l2_rd");
    step(1'b1, 1'b0, 4'h2, "to_l1");
    step(1'b0, 1'b1, 4'h0, "l1_rd_ignored");
    step(1'b1, 1'b1, 4'h6, "l1_rdwr");
    check("l1_rdwr.level_lit", 32'(level), 32'd2);

    // Full: read accepted, write dropped.
    while (q.size() < DEPTH) step(1'b1, 1'b0, WD'($urandom), "refill");
    step(1'b1, 1'b1, 4'hE, "full_rdwr");
    check("full_rdwr.level_lit", 32'(level), 32'd6);

    // Randomized traffic across several pointer wraps.
    do_reset();
    check_all("reset2");
    n_wr_acc = 0;
    target = 40;
    cycles = 0;
    while ((n_wr_acc < target || q.size() > 0) && cycles < 2000) begin
      if (n_wr_acc < target)
        step(($urandom_range(2, 0) != 0), ($urandom_range(1, 0) != 0), WD'($urandom), "rand");
      else
        step(1'b0, 1'b1, 4'h0, "rand_drain");
      cycles++;
    end
    check("rand_budget", 32'(cycles < 2000), 32'd1);
    check("rand_written", 32'(n_wr_acc), 32'(target));

    // Asynchronous reset between edges at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WD'($urandom), "pre_reset");
    check("pre_reset.level_lit", 32'(level), 32'd5);
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 4'h4, "post_reset_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
